// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SQUASH = 2'd2
    } ctrl_state_e;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use comparator: an EX load whose rd feeds a source of the ID instruction.
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic       i_id_valid,
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_id_uses_rs1,
    input  logic       i_id_uses_rs2,
    input  logic       i_ex_mem_read,
    input  logic [4:0] i_ex_rd,
    output logic       o_load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit    = i_id_uses_rs1 & (i_id_rs1 == i_ex_rd);
    assign rs2_hit    = i_id_uses_rs2 & (i_id_rs2 == i_ex_rd);
    assign o_load_use = i_ex_mem_read & (i_ex_rd != REG_X0) & i_id_valid & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: reset fetch hold, wrong-path squash,
// load-use bubbles, dmem freeze, and a saturating stall-cycle counter.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int RESET_HOLD_CYCLES = 2,
    parameter int STALL_CNT_W       = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_id_valid,
    input  logic [4:0]             i_id_rs1,
    input  logic [4:0]             i_id_rs2,
    input  logic                   i_id_uses_rs1,
    input  logic                   i_id_uses_rs2,
    input  logic                   i_ex_mem_read,
    input  logic [4:0]             i_ex_rd,
    input  logic                   i_ex_redirect,
    input  logic                   i_imem_ready,
    input  logic                   i_dmem_busy,
    output logic                   o_pc_write,
    output logic                   o_ifid_write,
    output logic                   o_ifid_flush,
    output logic                   o_if_valid,
    output logic                   o_idex_flush,
    output logic                   o_pipe_hold,
    output logic [STALL_CNT_W-1:0] o_stall_cnt
);

    localparam int HOLD_W = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);

    ctrl_state_e            state_q, state_d;
    logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
    logic                   lu_seen_q, lu_seen_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic load_use;
    logic lu_stall;
    logic squash;

    hazard_detect u_hazard_detect (
        .i_id_valid    (i_id_valid),
        .i_id_rs1      (i_id_rs1),
        .i_id_rs2      (i_id_rs2),
        .i_id_uses_rs1 (i_id_uses_rs1),
        .i_id_uses_rs2 (i_id_uses_rs2),
        .i_ex_mem_read (i_ex_mem_read),
        .i_ex_rd       (i_ex_rd),
        .o_load_use    (load_use)
    );

    // The bubble inserted for a load-use hazard reaches EX next cycle, so a hazard
    // seen right after its own stall is the same one and must not stall again.
    assign lu_stall = load_use & ~lu_seen_q;
    assign squash   = (state_q == ST_SQUASH);

    always_comb begin
        o_pc_write   = 1'b0;
        o_ifid_write = 1'b1;
        o_ifid_flush = 1'b0;
        o_if_valid   = 1'b0;
        o_idex_flush = 1'b0;
        o_pipe_hold  = 1'b0;
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        lu_seen_d    = lu_seen_q;

        if (state_q == ST_HOLD) begin
            lu_seen_d = 1'b0;
            if (hold_cnt_q == HOLD_LAST) state_d = ST_RUN;
            else                         hold_cnt_d = hold_cnt_q + 1'b1;
        end else if (i_dmem_busy) begin
            // EX is frozen, so redirect/load-use re-present once the freeze lifts.
            o_ifid_write = 1'b0;
            o_pipe_hold  = 1'b1;
        end else if (i_ex_redirect) begin
            o_pc_write   = 1'b1;
            o_ifid_write = 1'b0;
            o_ifid_flush = 1'b1;
            o_idex_flush = 1'b1;
            lu_seen_d    = 1'b0;
            state_d      = (squash || !i_imem_ready) ? ST_SQUASH : ST_RUN;
        end else begin
            if (lu_stall) begin
                o_ifid_write = 1'b0;
                o_idex_flush = 1'b1;
            end else if (!squash && i_imem_ready) begin
                o_pc_write = 1'b1;
                o_if_valid = 1'b1;
            end
            lu_seen_d = lu_stall;
            // In SQUASH a ready response is the stale wrong-path one: drop it, refetch.
            state_d   = (squash && !i_imem_ready) ? ST_SQUASH : ST_RUN;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q != ST_HOLD && !o_pc_write && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_HOLD;
            hold_cnt_q  <= '0;
            lu_seen_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            lu_seen_q   <= lu_seen_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized and directed check of pipeline_hazard_ctrl against a rule-level model.
module tb_pipeline_hazard_ctrl;

    localparam int HOLD_CYC = 2;
    localparam int CW       = 16;
    localparam int CNT_MAX  = (1 << CW) - 1;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_id_valid;
    logic [4:0]    i_id_rs1;
    logic [4:0]    i_id_rs2;
    logic          i_id_uses_rs1;
    logic          i_id_uses_rs2;
    logic          i_ex_mem_read;
    logic [4:0]    i_ex_rd;
    logic          i_ex_redirect;
    logic          i_imem_ready;
    logic          i_dmem_busy;
    logic          o_pc_write;
    logic          o_ifid_write;
    logic          o_ifid_flush;
    logic          o_if_valid;
    logic          o_idex_flush;
    logic          o_pipe_hold;
    logic [CW-1:0] o_stall_cnt;

    pipeline_hazard_ctrl #(.RESET_HOLD_CYCLES(HOLD_CYC), .STALL_CNT_W(CW)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_id_valid    (i_id_valid),
        .i_id_rs1      (i_id_rs1),
        .i_id_rs2      (i_id_rs2),
        .i_id_uses_rs1 (i_id_uses_rs1),
        .i_id_uses_rs2 (i_id_uses_rs2),
        .i_ex_mem_read (i_ex_mem_read),
        .i_ex_rd       (i_ex_rd),
        .i_ex_redirect (i_ex_redirect),
        .i_imem_ready  (i_imem_ready),
        .i_dmem_busy   (i_dmem_busy),
        .o_pc_write    (o_pc_write),
        .o_ifid_write  (o_ifid_write),
        .o_ifid_flush  (o_ifid_flush),
        .o_if_valid    (o_if_valid),
        .o_idex_flush  (o_idex_flush),
        .o_pipe_hold   (o_pipe_hold),
        .o_stall_cnt   (o_stall_cnt)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    // Model: remaining hold cycles, wrong-path-outstanding flag, last-cycle-was-LU-stall
    int m_hold_left;
    bit m_wrong_path;
    bit m_lu_prev;
    int m_cnt;
    bit e_pc, e_w, e_fl, e_v, e_xf, e_h, e_lu;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h @%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hold_left  = HOLD_CYC;
        m_wrong_path = 0;
        m_lu_prev    = 0;
        m_cnt        = 0;
    endtask

    task automatic model_out();
        bit hz;
        hz = i_ex_mem_read && (i_ex_rd != 0) && i_id_valid &&
             ((i_id_uses_rs1 && i_id_rs1 == i_ex_rd) || (i_id_uses_rs2 && i_id_rs2 == i_ex_rd));
        {e_pc, e_w, e_fl, e_v, e_xf, e_h, e_lu} = '0;
        if (!i_rst_n || m_hold_left > 0)  e_w = 1;
        else if (i_dmem_busy)             e_h = 1;
        else if (i_ex_redirect)           begin e_pc = 1; e_fl = 1; e_xf = 1; end
        else if (hz && !m_lu_prev)        begin e_xf = 1; e_lu = 1; end
        else if (m_wrong_path)            e_w = 1;
        else if (i_imem_ready)            begin e_pc = 1; e_w = 1; e_v = 1; end
        else                              e_w = 1;
    endtask

    task automatic model_edge();
        if (!i_rst_n) begin model_reset(); return; end
        if (m_hold_left > 0) begin m_hold_left--; return; end
        if (!e_pc && m_cnt < CNT_MAX) m_cnt++;
        if (i_dmem_busy) return;
        m_lu_prev = e_lu;
        if (i_ex_redirect)     m_wrong_path = m_wrong_path || !i_imem_ready;
        else if (i_imem_ready) m_wrong_path = 0;
    endtask

    task automatic cyc(input string tag);
        model_out();
        @(negedge i_clk);
        chk({tag, ".pc_write"},   32'(o_pc_write),   32'(e_pc));
        chk({tag, ".ifid_write"}, 32'(o_ifid_write), 32'(e_w));
        chk({tag, ".ifid_flush"}, 32'(o_ifid_flush), 32'(e_fl));
        chk({tag, ".if_valid"},   32'(o_if_valid),   32'(e_v));
        chk({tag, ".idex_flush"}, 32'(o_idex_flush), 32'(e_xf));
        chk({tag, ".pipe_hold"},  32'(o_pipe_hold),  32'(e_h));
        chk({tag, ".stall_cnt"},  32'(o_stall_cnt),  32'(m_cnt));
        @(posedge i_clk);
        model_edge();
        #1;
    endtask

    task automatic quiet();
        i_id_valid = 0; i_id_rs1 = 0; i_id_rs2 = 0; i_id_uses_rs1 = 0; i_id_uses_rs2 = 0;
        i_ex_mem_read = 0; i_ex_rd = 0; i_ex_redirect = 0; i_dmem_busy = 0;
    endtask

    task automatic set_lu();
        i_ex_mem_read = 1; i_ex_rd = 5'd5; i_id_valid = 1;
        i_id_rs1 = 5'd5; i_id_rs2 = 5'd1; i_id_uses_rs1 = 1; i_id_uses_rs2 = 1;
    endtask

    initial begin
        quiet();
        i_imem_ready = 1;
        i_rst_n = 0;
        model_reset();
        cyc("reset");
        i_rst_n = 1;
        cyc("hold1");
        cyc("hold2");
        cyc("run1");
        chk("run1.cnt_zero", 32'(o_stall_cnt), 32'd0);

        set_lu();
        cyc("lu_stall");
        i_ex_mem_read = 0;
        cyc("lu_after");
        set_lu(); i_ex_rd = 5'd0; i_id_rs1 = 5'd0;
        cyc("lu_rd0");
        set_lu(); i_id_uses_rs1 = 0;
        cyc("lu_nouse");
        quiet();

        i_ex_redirect = 1; i_imem_ready = 0;
        cyc("redir");
        i_ex_redirect = 0;
        cyc("squash1");
        cyc("squash2");
        i_imem_ready = 1;
        cyc("squash_drop");
        cyc("redir_run");

        set_lu(); i_ex_redirect = 1; i_dmem_busy = 1;
        for (int k = 0; k < 4; k++) cyc("busy");
        i_dmem_busy = 0;
        cyc("busy_release");
        quiet();
        cyc("settle");

        for (int n = 0; n < 3000; n++) begin
            i_rst_n       = ($urandom_range(0, 199) != 0);
            if (!i_rst_n) model_reset();
            i_id_valid    = ($urandom_range(0, 3) != 0);
            i_id_rs1      = 5'($urandom_range(0, 3));
            i_id_rs2      = 5'($urandom_range(0, 3));
            i_id_uses_rs1 = 1'($urandom);
            i_id_uses_rs2 = 1'($urandom);
            i_ex_mem_read = 1'($urandom);
            i_ex_rd       = 5'($urandom_range(0, 3));
            i_ex_redirect = ($urandom_range(0, 7) == 0);
            i_imem_ready  = ($urandom_range(0, 2) != 0);
            i_dmem_busy   = ($urandom_range(0, 7) == 0);
            cyc("rand");
        end

        quiet();
        i_rst_n = 1;
        i_imem_ready = 0;
        for (int n = 0; n < (1 << CW) + 8; n++) cyc("sat");
        chk("sat.cnt_ffff", 32'(o_stall_cnt), 32'hFFFF);

        i_rst_n = 0;
        model_reset();
        cyc("mid_rst");
        chk("mid_rst.cnt_zero", 32'(o_stall_cnt), 32'd0);
        i_rst_n = 1;
        i_imem_ready = 1;
        for (int k = 0; k < 4; k++) cyc("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
